// File: rtl/datapath_controller.sv
// Multi-cycle controller for the 16-register bus datapath: fetch, decode, one bus transfer per cycle.
// extern is a reserved word, so the external-mux enable is named extern_en.
module datapath_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  output logic        extern_en,
  output logic        readAddr,
  output logic [2:0]  sel,
  output logic [15:0] ren,
  output logic [15:0] rout,
  output logic        aen,
  output logic        gen,
  output logic        gout,
  output logic [15:0] outAddr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t      state, state_next;
  logic [15:0] ir, ir_next;
  logic [15:0] pc, pc_next;
  logic [3:0]  opcode, rx, ry;
  logic        unused_bits;

  assign opcode      = ir[15:12];
  assign rx          = ir[11:8];
  assign ry          = ir[7:4];
  assign unused_bits = ^ir[3:0];

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
      pc    <= '0;
    end else begin
      state <= state_next;
      ir    <= ir_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    state_next = state;
    ir_next    = ir;
    pc_next    = pc;
    extern_en  = 1'b0;
    readAddr   = 1'b0;
    sel        = '0;
    ren        = '0;
    rout       = '0;
    aen        = 1'b0;
    gen        = 1'b0;
    gout       = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    outAddr    = pc;

    unique case (state)
      IDLE: begin
        if (run) begin
          ir_next    = instr;
          pc_next    = pc + 16'd1;
          state_next = T1;
        end
      end
      T1: begin
        state_next = IDLE;
        unique case (opcode)
          4'h0: begin
            rout = onehot(ry);
            ren  = onehot(rx);
            done = 1'b1;
          end
          4'h1: begin
            // Immediate arrives on the datapath's data input; the PC skips past it.
            extern_en = 1'b1;
            ren       = onehot(rx);
            pc_next   = pc + 16'd1;
            done      = 1'b1;
          end
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            rout       = onehot(rx);
            aen        = 1'b1;
            state_next = T2;
          end
          4'h8: begin
            extern_en = 1'b1;
            readAddr  = 1'b1;
            ren       = onehot(rx);
            done      = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        rout       = onehot(ry);
        sel        = ir[14:12];
        gen        = 1'b1;
        state_next = T3;
      end
      T3: begin
        gout       = 1'b1;
        ren        = onehot(rx);
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset silences every output in the same cycle so an aborted instruction writes nothing.
    if (rst) begin
      extern_en = 1'b0;
      readAddr  = 1'b0;
      sel       = '0;
      ren       = '0;
      rout      = '0;
      aen       = 1'b0;
      gen       = 1'b0;
      gout      = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      outAddr   = '0;
    end
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench: drives the controller with a small register-file datapath model attached.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [15:0] instr, data;
  logic        extern_en, readAddr, aen, gen, gout, busy, done;
  logic [2:0]  sel;
  logic [15:0] ren, rout, outAddr;

  int errors = 0;
  int checks = 0;

  datapath_controller dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .extern_en(extern_en), .readAddr(readAddr), .sel(sel),
    .ren(ren), .rout(rout), .aen(aen), .gen(gen), .gout(gout),
    .outAddr(outAddr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: register file, A, G and the shared bus.
  logic [15:0] regs [16];
  logic [15:0] a_q = '0, g_q = '0, bus;

  initial for (int i = 0; i < 16; i++) regs[i] = '0;

  always_comb begin
    bus = '0;
    if (extern_en)  bus = readAddr ? outAddr : data;
    else if (gout)  bus = g_q;
    else for (int i = 0; i < 16; i++) if (rout[i]) bus = regs[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) if (ren[i]) regs[i] <= bus;
    if (aen) a_q <= bus;
    if (gen) g_q <= (sel == 3'd2) ? a_q + bus : a_q - bus;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus exclusivity, sampled every cycle away from the active edge.
  always @(negedge clk) begin
    int drivers;
    drivers = int'(extern_en) + int'(gout) + $countones(rout);
    check("bus_excl", {61'd0, drivers > 1, $countones(ren) > 1, $countones(rout) > 1}, 64'd0);
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] data;
    logic        ext;
    logic        rda;
    logic [15:0] ren;
    logic [15:0] rout;
    logic [15:0] pc;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'h1300, 16'h1234, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0001, 16'h1234}; // MVI r3
    vecs[1] = '{16'h1000, 16'h5555, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0003, 16'h5555}; // MVI r0
    vecs[2] = '{16'h0530, 16'h0000, 1'b0, 1'b0, 16'h0020, 16'h0008, 16'h0005, 16'h1234}; // MV r5<-r3
    vecs[3] = '{16'h8700, 16'h0000, 1'b1, 1'b1, 16'h0080, 16'h0000, 16'h0006, 16'h0006}; // MVPC r7
    vecs[4] = '{16'h9A00, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0007, 16'h0000}; // NOP
    vecs[5] = '{16'h0220, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0004, 16'h0008, 16'h0000}; // MV r2<-r2
    vecs[6] = '{16'h1F00, 16'hBEEF, 1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0009, 16'hBEEF}; // MVI r15
    vecs[7] = '{16'hF300, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h000B, 16'h1234}; // NOP op 15

    rst = 1'b1; run = 1'b0; instr = '0; data = '0;

    // Reset: outputs forced low while rst is high.
    @(negedge clk);
    check("rst_outs", {extern_en, readAddr, sel, ren, rout, aen, gen, gout, busy, done}, 64'd0);
    check("rst_pc", outAddr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", {busy, done, outAddr}, 18'd0);

    // Single-cycle opcodes from the table.
    foreach (vecs[i]) begin
      instr = vecs[i].instr; run = 1'b1;
      @(negedge clk);
      run = 1'b0; data = vecs[i].data;
      check($sformatf("v%0d_ext", i),  {extern_en, readAddr}, {vecs[i].ext, vecs[i].rda});
      check($sformatf("v%0d_ren", i),  ren, vecs[i].ren);
      check($sformatf("v%0d_rout", i), rout, vecs[i].rout);
      check($sformatf("v%0d_ctl", i),  {busy, done, aen, gen, gout}, 5'b11000);
      check($sformatf("v%0d_pc", i),   outAddr, vecs[i].pc);
      @(negedge clk);
      check($sformatf("v%0d_idle", i), {busy, done}, 2'b00);
      check($sformatf("v%0d_reg", i),  regs[vecs[i].instr[11:8]], vecs[i].val);
    end

    // ADD r5,r3 across T1..T3.
    instr = 16'h2530; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("add_t1", {rout, aen, gen, gout, ren, done, busy}, {16'h0020, 3'b100, 16'h0000, 2'b01});
    check("add_t1_pc", outAddr, 16'h000C);
    @(negedge clk);
    check("add_t2", {rout, sel, aen, gen, gout, done}, {16'h0008, 3'd2, 4'b0100});
    @(negedge clk);
    check("add_t3", {gout, ren, rout, gen, extern_en, done}, {1'b1, 16'h0020, 16'h0000, 3'b001});
    @(negedge clk);
    check("add_idle", {busy, done}, 2'b00);
    check("add_r5", regs[5], 16'h2468);

    // Reset in the middle of an ALU op: nothing written, no done.
    instr = 16'h2530; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("abort_pre", gen, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_outs", {extern_en, readAddr, sel, ren, rout, aen, gen, gout, busy, done}, 64'd0);
    check("abort_pc", outAddr, 16'h0000);
    @(negedge clk);
    check("abort_hold", {busy, done, ren, gout}, 34'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_post", {busy, done, outAddr}, 18'd0);
    check("abort_r5", regs[5], 16'h2468);
    instr = 16'h1100; run = 1'b1;
    @(negedge clk);
    run = 1'b0; data = 16'h0042;
    check("refetch_t1", {extern_en, ren, outAddr, done}, {1'b1, 16'h0002, 16'h0001, 1'b1});
    @(negedge clk);
    check("refetch_r1", regs[1], 16'h0042);

    // Back-to-back MV r1<-r3, ADD r1,r1, NOP with run held high.
    begin
      logic [7:0] exp_busy, exp_done;
      exp_busy = 8'b0101_1101;
      exp_done = 8'b0101_0001;
      instr = 16'h0130; run = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        check($sformatf("b2b_c%0d", c), {busy, done}, {exp_busy[c-1], exp_done[c-1]});
        if (c == 4) check("b2b_sel", sel, 3'd2);
        if (c == 1) instr = 16'h2110;
        if (c == 3) instr = 16'h1F00;
        if (c == 5) instr = 16'h9000;
        if (c == 7) run = 1'b0;
      end
      check("b2b_pc", outAddr, 16'h0005);
      check("b2b_r1", regs[1], 16'h2468);
    end

    // PC wrap: drive PC to 0xFFFF, then MVPC r0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    instr = 16'h9000; run = 1'b1;
    @(negedge clk);
    instr = 16'h1E00; data = 16'h0000;
    begin
      bit found;
      found = 1'b0;
      for (int cyc = 0; cyc < 70000 && !found; cyc++) begin
        @(negedge clk);
        if (!busy && outAddr == 16'hFFFF) found = 1'b1;
      end
      check("wrap_reach", found, 1'b1);
    end
    instr = 16'h8000;
    @(negedge clk);
    run = 1'b0;
    check("wrap_t1", {extern_en, readAddr, ren, done}, {2'b11, 16'h0001, 1'b1});
    check("wrap_pc", outAddr, 16'h0000);
    @(negedge clk);
    check("wrap_r0", regs[0], 16'h0000);
    check("wrap_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
# datapath_controller

Multi-cycle control unit that sequences the 16-register bus datapath: fetches a 16-bit instruction, decodes it, and drives the register load/drive enables, A/G register enables, ALU select and external-data/address-mux controls one bus transfer per cycle. It also owns the program counter that feeds the datapath's address input and signals completion of each instruction. One instruction is in flight at a time; no pipelining.

## Interface
- No parameters (data width fixed at 16, register count fixed at 16).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  request to fetch and execute `instr`; sampled only in IDLE
- instr  in  16  instruction word: [15:12] opcode, [11:8] rx, [7:4] ry, [3:0] ignored
- extern  out  1  drive external data/address mux onto bus
- readAddr  out  1  select PC (1) instead of `data` (0) on the external path
- sel  out  3  ALU operation select
- ren  out  16  one-hot register load enable
- rout  out  16  one-hot register bus-drive enable
- aen  out  1  load A register from bus
- gen  out  1  load G register from ALU result
- gout  out  1  drive G onto bus
- outAddr  out  16  program counter
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Opcodes: 0 MV rx←ry; 1 MVI rx←immediate (on `data` during T1); 2–7 ALU rx←rx op ry with sel = opcode[2:0]; 8 MVPC rx←PC; 9–15 NOP.
- Registered state: FSM state (IDLE, T1, T2, T3), IR (16 b), PC (16 b). All other outputs are combinational decodes of state and IR.
- IDLE: all enables 0. If run=1: IR←instr, PC←PC+1, go T1. Else stay.
- T1:
  - MV: rout[ry]=1, ren[rx]=1, done=1 → IDLE.
  - MVI: extern=1, readAddr=0, ren[rx]=1, PC←PC+1, done=1 → IDLE.
  - MVPC: extern=1, readAddr=1, ren[rx]=1, done=1 → IDLE (value written is PC after fetch increment).
  - ALU: rout[rx]=1, aen=1 → T2.
  - NOP: done=1, no enables → IDLE.
- T2 (ALU only): rout[ry]=1, sel=IR[14:12], gen=1 → T3.
- T3 (ALU only): gout=1, ren[rx]=1, done=1 → IDLE.
- rx==ry permitted for all opcodes (MV becomes a no-effect self copy; ALU uses same register twice).
- PC arithmetic modulo 2^16: 0xFFFF+1 wraps to 0x0000.
- Bus-exclusivity invariant: in every cycle at most one of {extern, any rout bit, gout} is 1; ren and rout each have popcount ≤1.

## Timing
- Reset: while rst=1 all outputs forced 0 combinationally; on the rising edge with rst=1, state←IDLE, IR←0, PC←0. busy, done, outAddr read 0 in the first cycle after reset.
- Reset mid-instruction (any of T1–T3) aborts; no ren/gen/aen issued in the rst cycle; no done pulse.
- Latency from run accepted (IDLE cycle) to done: MV/MVI/MVPC/NOP 1 cycle (done in T1); ALU 3 cycles (done in T3).
- Register writes land on the clock edge ending the cycle where ren is high.
- run held high: next instruction is accepted in the IDLE cycle directly after done; issue rate 2 cycles per single-cycle op, 4 per ALU op. run ignored while busy=1.
- MVI immediate must be valid on `data` throughout T1; instr is sampled only at acceptance.

## Test plan
- Reset: assert rst 2 cycles mid-run -> all outputs 0, outAddr=0x0000, next run fetches normally.
- MVI r3 (instr 0x1300), data=0x1234 in T1 -> extern=1, ren=0x0008 in T1, done in T1, r3=0x1234, outAddr advances by 2.
- MV r5←r3 (0x0530) -> rout=0x0008, ren=0x0020 same cycle, r5=0x1234.
- ADD r5,r3 (0x2530) -> T1 rout=0x0020 aen; T2 rout=0x0008 gen sel=2; T3 gout ren=0x0020 done; r5=0x2468.
- MVPC r0 with PC=0xFFFF -> PC wraps to 0x0000, r0=0x0000, readAddr=1 extern=1 in T1.
- Back-to-back run=1 over MV, ADD, NOP -> accepted only in IDLE, done pulses exactly at T1/T3/T1, bus-exclusivity assertion never fires.
